instr_fetch_master: RTL

Requester side of the instruction ROM interface: generates `sel_0`, `rd_en_rom` and `address_rom` to walk the instruction ROM sequentially. It captures each returned word one cycle later and buffers {address, instruction} pairs in a small FIFO. It presents them to a downstream consumer over a valid/ready handshake. It sits between the instruction ROM slave and the decode/execute stage.

---
 rtl/instr_fetch_master.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch_master.sv
// Sequential instruction ROM requester with a credit-gated {address, instruction} FIFO
// presented to the decode stage over a valid/ready handshake.
module instr_fetch_master #(
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter logic [31:0] LAST_ADDR  = 32'h0000_0010,
  parameter logic [31:0] ADDR_STEP  = 32'd4,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  output logic             sel_0,
  output logic             rd_en_rom,
  output logic [31:0]      address_rom,
  input  logic [31:0]      instr,
  output logic [31:0]      instr_out,
  output logic [31:0]      instr_addr,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [CNT_W-1:0] fifo_count,
  output logic             busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = CNT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STOPPING
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic               pending_q, pending_d;
  logic [31:0]        pending_addr_q, pending_addr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        mem_addr_q  [FIFO_DEPTH];
  logic [31:0]        mem_addr_d  [FIFO_DEPTH];
  logic [31:0]        mem_instr_q [FIFO_DEPTH];
  logic [31:0]        mem_instr_d [FIFO_DEPTH];

  logic issue;
  logic push;
  logic pop;

  // Credit check counts the in-flight word so the FIFO can never overflow
  assign issue = (state_q == ST_RUN) && !stop &&
                 ((OCC_W'(count_q) + OCC_W'(pending_q)) < OCC_W'(FIFO_DEPTH));
  assign push  = pending_q;
  assign pop   = (count_q != '0) && instr_ready;

  assign sel_0       = issue;
  assign rd_en_rom   = issue;
  assign address_rom = addr_q;
  assign instr_out   = mem_instr_q[rd_ptr_q];
  assign instr_addr  = mem_addr_q[rd_ptr_q];
  assign instr_valid = (count_q != '0);
  assign fifo_count  = count_q;
  assign busy        = (state_q != ST_IDLE);

  // FSM next state and fetch address generation
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    pending_d      = issue;
    pending_addr_d = pending_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_RUN;
          addr_d  = START_ADDR;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = pending_q ? ST_STOPPING : ST_IDLE;
        end
      end
      ST_STOPPING: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    if (issue) begin
      pending_addr_d = addr_q;
      addr_d         = (addr_q == LAST_ADDR) ? START_ADDR : addr_q + ADDR_STEP;
    end
  end

  // FIFO bookkeeping; returned word is captured the edge after its request
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    mem_addr_d  = mem_addr_q;
    mem_instr_d = mem_instr_q;

    if (push) begin
      mem_addr_d[wr_ptr_q]  = pending_addr_q;
      mem_instr_d[wr_ptr_q] = instr;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      addr_q         <= START_ADDR;
      pending_q      <= 1'b0;
      pending_addr_q <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_addr_q[i]  <= '0;
        mem_instr_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      pending_q      <= pending_d;
      pending_addr_q <= pending_addr_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      mem_addr_q     <= mem_addr_d;
      mem_instr_q    <= mem_instr_d;
    end
  end

endmodule
